// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared GPU scheduler state type and framebuffer constants
package gpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_RUN     = 2'd2,
        ST_RELEASE = 2'd3
    } sched_state_e;

    localparam int GPU_NUM_ENGINES       = 4;
    localparam int GPU_FBUF_ADDR_WIDTH   = 19;
    localparam int GPU_FBUF_DATA_WIDTH   = 8;
    localparam int GPU_TIMEOUT_CYCLES    = 400000;
    localparam int GPU_TIMEOUT_CNT_WIDTH = 20;

endpackage

// File: rtl/axi4_lite_gpu_fbuf_scheduler_if.sv
// rtl/axi4_lite_gpu_fbuf_scheduler_if.sv - engine request/status/write bundle and shared framebuffer port
interface axi4_lite_gpu_fbuf_scheduler_if
    import gpu_pkg::*;
#(
    parameter int NUM_ENGINES     = GPU_NUM_ENGINES,
    parameter int FBUF_ADDR_WIDTH = GPU_FBUF_ADDR_WIDTH,
    parameter int FBUF_DATA_WIDTH = GPU_FBUF_DATA_WIDTH
);
    localparam int IDW = $clog2(NUM_ENGINES);

    logic [NUM_ENGINES-1:0]                 req;
    logic [NUM_ENGINES-1:0]                 start;
    logic [NUM_ENGINES-1:0]                 eng_busy;
    logic [NUM_ENGINES-1:0]                 eng_done;
    logic [NUM_ENGINES-1:0]                 eng_err;
    logic [NUM_ENGINES-1:0]                 eng_fbuf_en_wr;
    logic [NUM_ENGINES-1:0]                 eng_fbuf_wrea;
    logic [NUM_ENGINES*FBUF_ADDR_WIDTH-1:0] eng_fbuf_addr;
    logic [NUM_ENGINES*FBUF_DATA_WIDTH-1:0] eng_fbuf_data;
    logic                                   fbuf_en_wr;
    logic                                   fbuf_wrea;
    logic [FBUF_ADDR_WIDTH-1:0]             fbuf_addr;
    logic [FBUF_DATA_WIDTH-1:0]             fbuf_data;
    logic                                   grant_valid;
    logic [IDW-1:0]                         grant_id;
    logic                                   timeout_err;
    logic                                   conflict_err;
    logic                                   idle;

    modport slave (
        input  req, eng_busy, eng_done, eng_err,
        input  eng_fbuf_en_wr, eng_fbuf_wrea, eng_fbuf_addr, eng_fbuf_data,
        output start, fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data,
        output grant_valid, grant_id, timeout_err, conflict_err, idle
    );

    modport master (
        output req, eng_busy, eng_done, eng_err,
        output eng_fbuf_en_wr, eng_fbuf_wrea, eng_fbuf_addr, eng_fbuf_data,
        input  start, fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data,
        input  grant_valid, grant_id, timeout_err, conflict_err, idle
    );

endinterface

// File: rtl/gpu_rr_picker.sv
// rtl/gpu_rr_picker.sv - combinational round-robin picker starting after last_grant
module gpu_rr_picker #(
    parameter int NUM_ENGINES = 4,
    localparam int IDW = $clog2(NUM_ENGINES)
) (
    input  logic [NUM_ENGINES-1:0] req_i,
    input  logic [IDW-1:0]         last_grant_i,
    output logic                   any_o,
    output logic [IDW-1:0]         winner_o
);
    int   idx;
    logic found;

    always_comb begin
        any_o    = |req_i;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int off = 1; off <= NUM_ENGINES; off++) begin
            idx = (int'(last_grant_i) + off) % NUM_ENGINES;
            if (!found && req_i[idx]) begin
                winner_o = IDW'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_lite_gpu_fbuf_scheduler.sv
// rtl/axi4_lite_gpu_fbuf_scheduler.sv - round-robin owner of the framebuffer write port; GPU_SCHED_TIMEOUT_EN adds a RUN watchdog
module axi4_lite_gpu_fbuf_scheduler
    import gpu_pkg::*;
#(
    parameter int NUM_ENGINES     = GPU_NUM_ENGINES,
    parameter int FBUF_ADDR_WIDTH = GPU_FBUF_ADDR_WIDTH,
    parameter int FBUF_DATA_WIDTH = GPU_FBUF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES  = GPU_TIMEOUT_CYCLES
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    axi4_lite_gpu_fbuf_scheduler_if.slave bus
);
    localparam int IDW = $clog2(NUM_ENGINES);

    sched_state_e           state_q, state_d;
    logic [IDW-1:0]         grant_id_q, grant_id_d;
    logic [IDW-1:0]         last_grant_q, last_grant_d;
    logic                   conflict_q, conflict_d;
    logic                   timeout_q, timeout_d;
    logic                   pick_any;
    logic [IDW-1:0]         pick_winner;
    logic                   tmo_hit;
    logic                   granted;
    logic                   run_out;
    logic [NUM_ENGINES-1:0] grant_onehot;
    logic [NUM_ENGINES-1:0] grant_mask;
    logic                   unused_busy;

    assign unused_busy = ^bus.eng_busy;

    gpu_rr_picker #(.NUM_ENGINES(NUM_ENGINES)) u_picker (
        .req_i        (bus.req),
        .last_grant_i (last_grant_q),
        .any_o        (pick_any),
        .winner_o     (pick_winner)
    );

`ifdef GPU_SCHED_TIMEOUT_EN
    logic [GPU_TIMEOUT_CNT_WIDTH-1:0] run_cnt_q;

    // Held at zero outside RUN so it is already clear on RUN entry.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != ST_RUN) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == ST_RUN) &&
                     (run_cnt_q == GPU_TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    assign grant_onehot = NUM_ENGINES'(1) << grant_id_q;
    assign granted      = (state_q == ST_START) || (state_q == ST_RUN);
    assign grant_mask   = granted ? grant_onehot : '0;
    assign run_out      = (state_q == ST_RUN) && !rst_i;

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        timeout_d    = 1'b0;
        conflict_d   = |(bus.eng_fbuf_en_wr & ~grant_mask);
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_winner;
                    state_d    = ST_START;
                end
            end
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                // Done/err take priority so a same-cycle timeout is not reported.
                if (bus.eng_done[grant_id_q] || bus.eng_err[grant_id_q]) begin
                    state_d = ST_RELEASE;
                end else if (tmo_hit) begin
                    state_d   = ST_RELEASE;
                    timeout_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                last_grant_d = grant_id_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= IDW'(NUM_ENGINES - 1);
            conflict_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            conflict_q   <= conflict_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.start        = (state_q == ST_START && !rst_i) ? grant_onehot : '0;
    assign bus.fbuf_en_wr   = run_out & bus.eng_fbuf_en_wr[grant_id_q];
    assign bus.fbuf_wrea    = run_out & bus.eng_fbuf_wrea[grant_id_q];
    assign bus.fbuf_addr    = run_out ? bus.eng_fbuf_addr[grant_id_q*FBUF_ADDR_WIDTH +: FBUF_ADDR_WIDTH] : '0;
    assign bus.fbuf_data    = run_out ? bus.eng_fbuf_data[grant_id_q*FBUF_DATA_WIDTH +: FBUF_DATA_WIDTH] : '0;
    assign bus.grant_valid  = granted && !rst_i;
    assign bus.grant_id     = rst_i ? '0 : grant_id_q;
    assign bus.timeout_err  = timeout_q && !rst_i;
    assign bus.conflict_err = conflict_q && !rst_i;
    assign bus.idle         = (state_q == ST_IDLE) || rst_i;

endmodule

// File: tb/tb_axi4_lite_gpu_fbuf_scheduler.sv
// tb/tb_axi4_lite_gpu_fbuf_scheduler.sv - directed scoreboard bench for the framebuffer scheduler
module tb_axi4_lite_gpu_fbuf_scheduler;
    localparam int NE = 4;
    localparam int AW = 19;
    localparam int DW = 8;
`ifdef GPU_SCHED_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 400000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   model_last = NE - 1;
    int   exp_q[$];

    always #5 clk = ~clk;

    axi4_lite_gpu_fbuf_scheduler_if #(.NUM_ENGINES(NE), .FBUF_ADDR_WIDTH(AW), .FBUF_DATA_WIDTH(DW)) bus ();

    axi4_lite_gpu_fbuf_scheduler #(
        .NUM_ENGINES(NE), .FBUF_ADDR_WIDTH(AW), .FBUF_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [NE-1:0] r, input int last);
        for (int off = 1; off <= NE; off++) begin
            if (r[(last + off) % NE]) return (last + off) % NE;
        end
        return -1;
    endfunction

    task automatic push_grant(input logic [NE-1:0] r);
        int w;
        w = rr(r, model_last);
        exp_q.push_back(w);
        model_last = w;
    endtask

    task automatic clear_eng();
        bus.eng_busy       = '0;
        bus.eng_done       = '0;
        bus.eng_err        = '0;
        bus.eng_fbuf_en_wr = '0;
        bus.eng_fbuf_wrea  = '0;
        bus.eng_fbuf_addr  = '0;
        bus.eng_fbuf_data  = '0;
    endtask

    task automatic check_quiet_port(input string tag);
        chk({tag, "_en"}, {31'd0, bus.fbuf_en_wr}, 32'd0);
        chk({tag, "_addr"}, {13'd0, bus.fbuf_addr}, 32'd0);
        chk({tag, "_data"}, {24'd0, bus.fbuf_data}, 32'd0);
    endtask

    task automatic wait_start(output int exp_id);
        bit got;
        logic [NE-1:0] oh;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cyc();
            if (bus.start !== '0) got = 1'b1;
        end
        chk("start_seen", {31'd0, got}, 32'd1);
        chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        exp_id = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
        oh = '0;
        oh[exp_id] = 1'b1;
        chk("start_onehot", {28'd0, bus.start}, {28'd0, oh});
        chk("grant_id", {30'd0, bus.grant_id}, exp_id);
        chk("gv_start", {31'd0, bus.grant_valid}, 32'd1);
        chk("idle_start", {31'd0, bus.idle}, 32'd0);
        check_quiet_port("port_start");
    endtask

    task automatic serve(input int nwr, input bit use_err, input bit intr, input logic [NE-1:0] req_hold);
        int exp_id;
        int other;
        bit prev_intr;
        wait_start(exp_id);
        bus.req = req_hold;
        other = (exp_id + 1) % NE;
        prev_intr = 1'b0;
        for (int i = 0; i < nwr; i++) begin
            cyc();
            clear_eng();
            bus.eng_busy[exp_id] = 1'b1;
            bus.eng_fbuf_en_wr[exp_id] = 1'b1;
            bus.eng_fbuf_wrea[exp_id] = 1'b1;
            bus.eng_fbuf_addr[exp_id*AW +: AW] = AW'(32'h40 + i);
            bus.eng_fbuf_data[exp_id*DW +: DW] = DW'(i * 3 + exp_id);
            if (intr) begin
                bus.eng_fbuf_en_wr[other] = 1'b1;
                bus.eng_fbuf_addr[other*AW +: AW] = AW'(32'h100);
                bus.eng_fbuf_data[other*DW +: DW] = 8'hEE;
            end
            #1;
            chk("run_start_low", {28'd0, bus.start}, 32'd0);
            chk("run_gv", {31'd0, bus.grant_valid}, 32'd1);
            chk("port_en", {31'd0, bus.fbuf_en_wr}, 32'd1);
            chk("port_wrea", {31'd0, bus.fbuf_wrea}, 32'd1);
            chk("port_addr", {13'd0, bus.fbuf_addr}, 32'h40 + i);
            chk("port_data", {24'd0, bus.fbuf_data}, (i * 3 + exp_id) & 32'hff);
            chk("conflict", {31'd0, bus.conflict_err}, {31'd0, prev_intr});
            chk("timeout_low", {31'd0, bus.timeout_err}, 32'd0);
            prev_intr = intr;
        end
        cyc();
        clear_eng();
        if (use_err) bus.eng_err[exp_id] = 1'b1;
        else bus.eng_done[exp_id] = 1'b1;
        #1;
        chk("done_gv", {31'd0, bus.grant_valid}, 32'd1);
        chk("done_conflict", {31'd0, bus.conflict_err}, {31'd0, prev_intr});
        check_quiet_port("port_done");
        cyc();
        clear_eng();
        chk("rel_gv", {31'd0, bus.grant_valid}, 32'd0);
        chk("rel_idle", {31'd0, bus.idle}, 32'd0);
        chk("rel_conflict", {31'd0, bus.conflict_err}, 32'd0);
        chk("rel_timeout", {31'd0, bus.timeout_err}, 32'd0);
        check_quiet_port("port_rel");
        cyc();
        chk("idle_back", {31'd0, bus.idle}, 32'd1);
        chk("idle_start_low", {28'd0, bus.start}, 32'd0);
    endtask

    initial begin
        int eid;
        bus.req = '0;
        clear_eng();
        cyc();
        cyc();
        chk("rst_idle", {31'd0, bus.idle}, 32'd1);
        chk("rst_start", {28'd0, bus.start}, 32'd0);
        chk("rst_gv", {31'd0, bus.grant_valid}, 32'd0);
        chk("rst_gid", {30'd0, bus.grant_id}, 32'd0);
        chk("rst_tmo", {31'd0, bus.timeout_err}, 32'd0);
        chk("rst_conf", {31'd0, bus.conflict_err}, 32'd0);
        check_quiet_port("rst_port");
        rst = 1'b0;
        cyc();

        // Single requester, ten mirrored writes.
        bus.req = 4'b0001;
        push_grant(4'b0001);
        serve(10, 1'b0, 1'b0, 4'b0000);

        // All engines requesting: order 0,1,2,3,0.
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push_grant(4'b1111);
            serve(4, 1'b0, 1'b0, (k == 4) ? 4'b0000 : 4'b1111);
        end

        // Engine 2 errors immediately, then engine 3 is served.
        bus.req = 4'b1100;
        push_grant(4'b1100);
        serve(0, 1'b1, 1'b0, 4'b1000);
        push_grant(4'b1000);
        serve(2, 1'b0, 1'b0, 4'b0000);

        // Engine 1 intrudes while engine 0 owns the port.
        bus.req = 4'b0001;
        push_grant(4'b0001);
        serve(6, 1'b0, 1'b1, 4'b0000);

`ifdef GPU_SCHED_TIMEOUT_EN
        bus.req = 4'b0110;
        push_grant(4'b0110);
        wait_start(eid);
        bus.req = 4'b0100;
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            cyc();
            chk("tmo_run_gv", {31'd0, bus.grant_valid}, 32'd1);
            chk("tmo_early", {31'd0, bus.timeout_err}, 32'd0);
        end
        cyc();
        chk("tmo_pulse", {31'd0, bus.timeout_err}, 32'd1);
        chk("tmo_rel_gv", {31'd0, bus.grant_valid}, 32'd0);
        cyc();
        chk("tmo_once", {31'd0, bus.timeout_err}, 32'd0);
        chk("tmo_idle", {31'd0, bus.idle}, 32'd1);
        push_grant(4'b0100);
        serve(3, 1'b0, 1'b0, 4'b0000);
`else
        bus.req = 4'b0010;
        push_grant(4'b0010);
        serve(40, 1'b0, 1'b0, 4'b0000);
`endif

        // Reset in the middle of RUN.
        bus.req = 4'b0001;
        push_grant(4'b0001);
        wait_start(eid);
        bus.req = 4'b0000;
        cyc();
        bus.eng_fbuf_en_wr[eid] = 1'b1;
        bus.eng_fbuf_addr[eid*AW +: AW] = 19'h55;
        rst = 1'b1;
        cyc();
        chk("mrst_idle", {31'd0, bus.idle}, 32'd1);
        chk("mrst_start", {28'd0, bus.start}, 32'd0);
        chk("mrst_gv", {31'd0, bus.grant_valid}, 32'd0);
        chk("mrst_gid", {30'd0, bus.grant_id}, 32'd0);
        chk("mrst_conf", {31'd0, bus.conflict_err}, 32'd0);
        check_quiet_port("mrst_port");
        clear_eng();
        rst = 1'b0;
        model_last = NE - 1;
        bus.req = 4'b0110;
        push_grant(4'b0110);
        serve(3, 1'b0, 1'b0, 4'b0000);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_gpu_fbuf_scheduler.md
# axi4_lite_gpu_fbuf_scheduler

Schedules the GPU execute engines (rect fill and its siblings) onto the single framebuffer write port. Pending engines are granted round-robin. The granted engine receives a one-cycle `start`, and the block muxes that engine's framebuffer write signals onto the shared port until it reports done or err. It sits between the AXI4-Lite GPU register front end (which raises per-engine requests) and the framebuffer BRAM write port.

## Interface
- `NUM_ENGINES`, 4, number of execute engines sharing the port (2..8)
- `FBUF_ADDR_WIDTH`, 19, framebuffer address width
- `FBUF_DATA_WIDTH`, 8, framebuffer data width
- `TIMEOUT_CYCLES`, 400000, RUN-state watchdog limit; exceeds a full 640x480 fill
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  NUM_ENGINES  engine has a command ready; level, held until its start
- `start`  out  NUM_ENGINES  one-hot one-cycle start to the granted engine
- `eng_busy`, `eng_done`, `eng_err`  in  NUM_ENGINES each  engine status; done/err are one-cycle pulses
- `eng_fbuf_en_wr`, `eng_fbuf_wrea`  in  NUM_ENGINES each  per-engine write strobes
- `eng_fbuf_addr`  in  NUM_ENGINES*FBUF_ADDR_WIDTH  packed; engine i at bits [i*AW +: AW]
- `eng_fbuf_data`  in  NUM_ENGINES*FBUF_DATA_WIDTH  packed likewise
- `fbuf_en_wr`, `fbuf_wrea`  out  1 each  shared port strobes
- `fbuf_addr`  out  FBUF_ADDR_WIDTH  shared port address
- `fbuf_data`  out  FBUF_DATA_WIDTH  shared port data
- `grant_valid`  out  1  high in START and RUN
- `grant_id`  out  $clog2(NUM_ENGINES)  index of the granted engine
- `timeout_err`  out  1  one-cycle pulse when the watchdog aborts a grant
- `conflict_err`  out  1  one-cycle pulse when a non-granted engine asserts `eng_fbuf_en_wr`
- `idle`  out  1  high in IDLE

## Operation
- States and transitions:
  - IDLE: if any `req`, select the granted engine and go to START; otherwise stay.
  - START: go to RUN.
  - RUN: go to RELEASE on the granted engine's done, err, or a timeout.
  - RELEASE: go to IDLE.
- Arbitration:
  - Round-robin search begins at (`last_grant`+1) mod NUM_ENGINES.
  - `last_grant` resets to NUM_ENGINES-1, so engine 0 wins the first arbitration.
  - `last_grant` updates in RELEASE.
- START: `start[grant_id]`=1 for exactly one cycle. All other `start` bits are 0 at all times.
- Mux gating:
  - In RUN, the shared port equals the granted engine's `en_wr`/`wrea`/`addr`/`data`, combinationally.
  - In every other state, all shared-port outputs are 0.
  - Writes from non-granted engines are always dropped. Each such cycle pulses `conflict_err`.
- `req` and status from non-granted engines are ignored. A `req` drop during START/RUN/RELEASE has no effect on the current grant.
- Grant retirement:
  - Engine err (e.g. a rect command with invalid corners) retires the grant like done.
  - No retry; the requester re-raises `req` if it wants one.
- Simultaneous events:
  - done and timeout in the same cycle: done wins, no `timeout_err`.
  - done and err in the same cycle: single RELEASE.
- Reset mid-operation:
  - Next state is IDLE and `last_grant` = NUM_ENGINES-1.
  - All outputs are 0 except `idle`=1.
  - No `start` is issued in the reset cycle.

## Timing
- Reset values: `start`=0, shared port=0, `grant_valid`=0, `grant_id`=0, `timeout_err`=0, `conflict_err`=0, `idle`=1.
- Latency:
  - `req` sampled in IDLE at cycle N gives `start` at N+1 and RUN from N+2.
  - The engine's first write appears on the port in its first BUSY cycle (N+2).
- Done pulse at cycle M: RELEASE at M+1, IDLE at M+2. Earliest next `start` is M+3.
- Overhead per command is 3 idle port cycles (IDLE, START, RELEASE).
- `conflict_err` and `timeout_err` are registered: they pulse one cycle after the causing event.

## Configuration
- `GPU_SCHED_TIMEOUT_EN` defined:
  - A 20-bit RUN counter clears on entry to RUN.
  - When it reaches TIMEOUT_CYCLES-1 without done/err, go to RELEASE and pulse `timeout_err`.
  - The aborted engine's further writes are then gated off and counted as conflicts.
- `GPU_SCHED_TIMEOUT_EN` undefined: no counter, RUN waits indefinitely, `timeout_err` tied to 0.

## Structure
- Shared package `gpu_pkg`: scheduler state enum (IDLE, START, RUN, RELEASE), default `TIMEOUT_CYCLES` constant, framebuffer width constants shared with the execute engines.
- Sub-module `gpu_rr_picker`: combinational round-robin picker. Input: `req` vector and `last_grant`. Outputs: `any` and `winner` index.

## Test plan
- Reset, then `req`=4'b0001; engine 0 done 10 cycles after start:
  - `start`=4'b0001 one cycle after `req`.
  - The port mirrors engine 0 for 10 cycles, then 0.
  - `idle` returns 2 cycles after done.
- `req`=4'b1111 held, each engine done after 5 cycles -> grant order 0,1,2,3,0; each `start` exactly one cycle.
- Engine 2 returns err one cycle after start -> RELEASE; next grant goes to engine 3; no writes reach the port.
- Engine 1 drives `eng_fbuf_en_wr`=1, addr=0x100, while engine 0 is granted -> port shows engine 0 only; `conflict_err` pulses each such cycle.
- `GPU_SCHED_TIMEOUT_EN` with TIMEOUT_CYCLES=16, engine never done:
  - `timeout_err` pulses exactly once, 16 cycles into RUN.
  - Then RELEASE, then the next requester is granted.
- `rst` asserted mid-RUN: next cycle all outputs are 0 and `idle`=1. After release with `req`=4'b0110, engine 1 is granted first.
